intermediator_window_ctrl: RTL and testbench
============================================

INTERMEDIATOR_WINDOW_CTRL -- requirements
Module: intermediator_window_ctrl

Interface
REQ-001 Parameter INTERMEDIATOR_DEPTH, default 1024, meaning rows in the intermediator, power of two, at least 8.
REQ-002 Parameter LOG2_INTERMEDIATOR_DEPTH, default log2(INTERMEDIATOR_DEPTH-1), meaning row index width W.
REQ-003 Parameter FADE_CYCLES, default 128, meaning settle cycles after a half flip before draining.
REQ-004 Parameter EOF_DELAY, default 512, meaning pipeline quiesce cycles after eof before the final flip.
REQ-005 Port clk, input, 1, meaning the single clock for all state.
REQ-006 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-007 Port row_valid, input, 1, meaning the multiplier lane presents a row this cycle.
REQ-008 Port row, input, W, meaning the row index of that product.
REQ-009 Port eof, input, 1, meaning a single-cycle end-of-matrix pulse.
REQ-010 Port drain_valid, output, 1, meaning the drain request is valid.
REQ-011 Port drain_row, output, W, meaning the row to store to y.
REQ-012 Port drain_ready, input, 1, meaning the datapath accepts the drain.
REQ-013 Port row_reject, output, 1, meaning the current row must go to the overflow FIFO.
REQ-014 Port stall, output, 1, meaning upstream must hold new rows.
REQ-015 Port done, output, 1, meaning a single-cycle pulse when the final drain completes.
REQ-016 Port window_err, output, 1, meaning a sticky protocol error flag.

Function
REQ-017 Pointers win_begin and win_end are each W bits; the active half is win_end[W-1]; the window is closed when win_begin == win_end.
REQ-018 States are RUN, FADE, DRAIN, EOF_WAIT, FINAL_FADE, FINAL_DRAIN.
REQ-019 RUN, flip: when row_valid is high, row[W-1] differs from the active half, and the window is closed, win_end[W-1] toggles at the next edge, the timer loads FADE_CYCLES, and the state goes to FADE.
REQ-020 RUN, overflow: when row_valid is high, row[W-1] differs from the active half, and the window is open, row_reject is asserted combinationally in the same cycle.
REQ-021 FADE: the timer decrements each cycle; on reaching 0 the state goes to DRAIN at the next edge.
REQ-022 DRAIN: drain_valid is registered, drain_row = win_begin, and drain_valid is held until accepted.
REQ-023 DRAIN: on each drain_valid && drain_ready, win_begin increments by 1 (mod DEPTH), giving one row per cycle at most.
REQ-024 DRAIN: when win_begin reaches win_end, drain_valid drops in the same cycle and the state returns to RUN.
REQ-025 While drain_valid is high and drain_ready is low, drain_row shall not change.
REQ-026 In RUN, eof, or an eof_pending latched in any other state, moves the state to EOF_WAIT with the timer loaded to EOF_DELAY; eof_pending is cleared on entry.
REQ-027 If eof and a flip condition coincide in the same cycle, the flip is taken first and eof is latched as pending.
REQ-028 When the EOF_WAIT timer reaches 0, win_end[W-1] toggles and the state goes to FINAL_FADE, timed by FADE_CYCLES.
REQ-029 FINAL_FADE then goes to FINAL_DRAIN, which drains as DRAIN does.
REQ-030 On completion of FINAL_DRAIN, done pulses for 1 cycle and the state returns to RUN with the pointers retained.
REQ-031 stall = (state != RUN) || eof_pending || row_reject.
REQ-032 Rows with row[W-1] equal to the active half are never rejected.
REQ-033 The timer and all pointer arithmetic wrap modulo 2^W with no saturation.

Reset
REQ-034 On rst, the block asynchronously enters RUN with win_begin = win_end = 0, timer = 0, and eof_pending = 0.
REQ-035 Reset values of outputs: drain_valid, row_reject, stall, done and window_err are 0; drain_row is 0.
REQ-036 A reset asserted mid-DRAIN or mid-EOF_WAIT abandons the operation with no done pulse.

Configuration
REQ-037 With INTERMEDIATOR_WINDOW_CHECK_EN defined, window_err sets and stays set until rst when either of the following occurs:
- a flip is requested while the window is open in a non-RUN state;
- row_valid arrives with row[W-1] differing from the active half during DRAIN.
REQ-038 Without INTERMEDIATOR_WINDOW_CHECK_EN, window_err is tied to 0 and no check logic is synthesized.

Structure
REQ-039 The state encoding and the default FADE_CYCLES and EOF_DELAY constants shall live in the shared package intermediator_pkg.
REQ-040 The FADE and EOF timing shall share one down-counter sub-module, cycle_timer, with load, value, and zero flag.

Verification (INTERMEDIATOR_DEPTH=16, FADE_CYCLES=4, EOF_DELAY=8)
REQ-041 After reset, rows 3, 5 and 7 are accepted: no stall, no row_reject, win_end = 0.
REQ-042 Row 9 with the window closed: stall rises next cycle, FADE lasts 4 cycles, then drain_row 0..7 is issued and win_begin = 8, then RUN.
REQ-043 DRAIN with drain_ready toggled 1,0,1: drain_row holds during the low cycle and no row is skipped or duplicated.
REQ-044 Row 2 during DRAIN: row_reject = 1 in the same cycle and, with the macro defined, window_err = 1.
REQ-045 eof in RUN: 8 quiet cycles, then a flip, 4 fade cycles, 8 drains, and exactly one done pulse.
REQ-046 rst asserted mid-EOF_WAIT: all outputs are 0 immediately and no done pulse occurs.

Source files
------------

// File: rtl/intermediator_pkg.sv
// intermediator_pkg: shared FSM encoding and default timing for the intermediator window controller
// Contents: state_t (controller states), FADE_CYCLES_DEF, EOF_DELAY_DEF
package intermediator_pkg;
    typedef enum logic [2:0] {RUN, FADE, DRAIN, EOF_WAIT, FINAL_FADE, FINAL_DRAIN} state_t;
    localparam int FADE_CYCLES_DEF = 128;
    localparam int EOF_DELAY_DEF = 512;
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter shared by the fade and end-of-frame waits
// Ports: clk, rst (async, active high), load/load_val (load wins over dec),
//        dec (count down one, wrapping), value (current count),
//        zero (this cycle's decrement lands on zero)
module cycle_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             zero
);
    always_ff @(posedge clk or posedge rst)
        if (rst) value <= '0;
        else if (load) value <= load_val;
        else if (dec) value <= value - WIDTH'(1);
    // Flagging one early makes a load of N give exactly N cycles in the timed state.
    assign zero = value == WIDTH'(1);
endmodule

// File: rtl/intermediator_window_ctrl.sv
// intermediator_window_ctrl: half-buffer window flip/drain controller for the intermediator
// Ports: clk, rst (async, active high); row_valid/row from the multiplier lane;
//        eof end-of-matrix pulse; drain_valid/drain_row/drain_ready drain handshake;
//        row_reject (send row to overflow FIFO); stall (hold upstream);
//        done (final drain complete pulse); window_err (sticky protocol error)
// Option: define INTERMEDIATOR_WINDOW_CHECK_EN to build the window_err checker.
module intermediator_window_ctrl
    import intermediator_pkg::*;
#(
    parameter int INTERMEDIATOR_DEPTH = 1024,
    parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH - 1),
    parameter int FADE_CYCLES = FADE_CYCLES_DEF,
    parameter int EOF_DELAY = EOF_DELAY_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                row_valid,
    input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
    input  logic                                eof,
    output logic                                drain_valid,
    output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] drain_row,
    input  logic                                drain_ready,
    output logic                                row_reject,
    output logic                                stall,
    output logic                                done,
    output logic                                window_err
);
    localparam int W = LOG2_INTERMEDIATOR_DEPTH;
    state_t state, state_nx;
    logic [W-1:0] win_begin, win_end, tmr_load_val;
    logic eof_pending, eof_pending_nx, tmr_load, tmr_dec, tmr_zero, half_flip;
    logic closed, flip_req, drain_fire, drain_last;
    assign closed = win_begin == win_end;
    assign flip_req = row_valid && (row[W-1] != win_end[W-1]);
    assign row_reject = flip_req && !closed;
    assign drain_valid = state == DRAIN || state == FINAL_DRAIN;
    assign drain_row = win_begin;
    assign drain_fire = drain_valid && drain_ready;
    assign drain_last = (win_begin + W'(1)) == win_end;
    assign stall = state != RUN || eof_pending || row_reject;
    cycle_timer #(.WIDTH(W)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(tmr_load),
        .dec(tmr_dec),
        .load_val(tmr_load_val),
        .value(),
        .zero(tmr_zero)
    );
    always_comb begin
        state_nx = state;
        eof_pending_nx = eof_pending || (eof && state != RUN);
        tmr_load = 1'b0;
        tmr_load_val = W'(FADE_CYCLES);
        tmr_dec = 1'b0;
        half_flip = 1'b0;
        case (state)
            RUN:
                if (flip_req && closed) begin
                    // A flip outranks a coincident eof, which waits as pending.
                    state_nx = FADE;
                    tmr_load = 1'b1;
                    half_flip = 1'b1;
                    eof_pending_nx = eof_pending || eof;
                end else if (eof || eof_pending) begin
                    state_nx = EOF_WAIT;
                    tmr_load = 1'b1;
                    tmr_load_val = W'(EOF_DELAY);
                    eof_pending_nx = 1'b0;
                end
            FADE, FINAL_FADE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_nx = state == FADE ? DRAIN : FINAL_DRAIN;
            end
            DRAIN, FINAL_DRAIN:
                if (drain_fire && drain_last) state_nx = RUN;
            EOF_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_nx = FINAL_FADE;
                    tmr_load = 1'b1;
                    half_flip = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            win_begin <= '0;
            win_end <= '0;
            eof_pending <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_nx;
            eof_pending <= eof_pending_nx;
            done <= state == FINAL_DRAIN && drain_fire && drain_last;
            if (drain_fire) win_begin <= win_begin + W'(1);
            if (half_flip) win_end[W-1] <= ~win_end[W-1];
        end
`ifdef INTERMEDIATOR_WINDOW_CHECK_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) window_err <= 1'b0;
        else if ((state != RUN && row_reject) || (state == DRAIN && flip_req)) window_err <= 1'b1;
`else
    assign window_err = 1'b0;
`endif
endmodule

// File: tb/tb_intermediator_window_ctrl.sv
// tb_intermediator_window_ctrl: scoreboard bench for intermediator_window_ctrl (DEPTH 16, FADE 4, EOF 8)
module tb_intermediator_window_ctrl;
    localparam int W = 4;
`ifdef INTERMEDIATOR_WINDOW_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, row_valid = 1'b0, eof = 1'b0, drain_ready = 1'b1;
    logic [W-1:0] row = '0;
    logic drain_valid, row_reject, stall, done, window_err;
    logic [W-1:0] drain_row;
    int tests = 0, fails = 0, done_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] ok_rows[3] = '{4'd3, 4'd5, 4'd7};

    intermediator_window_ctrl #(
        .INTERMEDIATOR_DEPTH(16),
        .LOG2_INTERMEDIATOR_DEPTH(W),
        .FADE_CYCLES(4),
        .EOF_DELAY(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .row_valid(row_valid),
        .row(row),
        .eof(eof),
        .drain_valid(drain_valid),
        .drain_row(drain_row),
        .drain_ready(drain_ready),
        .row_reject(row_reject),
        .stall(stall),
        .done(done),
        .window_err(window_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected drain row on each accepted drain, checks hold while stalled.
    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
        if (drain_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL drain_extra: got row %0d expected no drain", drain_row);
            end else if (drain_ready) chk("drain_row", drain_row, exp_q.pop_front());
            else chk("drain_hold", drain_row, exp_q[0]);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        @(negedge clk);
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_reject", row_reject, 0);
        chk("rst_done", done, 0);
        chk("rst_err", window_err, 0);
        chk("rst_drain_row", drain_row, 0);
        step;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            row_valid = 1'b1;
            row = ok_rows[i];
            @(negedge clk);
            chk("accept_stall", stall, 0);
            chk("accept_reject", row_reject, 0);
            step;
        end
        row = 4'd9;
        for (int i = 0; i < 8; i++) exp_q.push_back(4'(i));
        @(negedge clk);
        chk("flip_stall", stall, 0);
        chk("flip_reject", row_reject, 0);
        step;
        row_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fade_stall", stall, 1);
            chk("fade_idle", drain_valid, 0);
            step;
        end
        chk("drain_start", drain_valid, 1);
        k = 0;
        while (drain_valid && k < 40) begin
            drain_ready = (k % 3) != 1;
            row_valid = k == 2;
            row = 4'd2;
            @(negedge clk);
            if (k == 2) begin
                chk("drain_reject", row_reject, 1);
                chk("drain_reject_stall", stall, 1);
            end
            if (k == 3) chk("window_err", window_err, ERR_EXP);
            step;
            k++;
        end
        chk("drain_timeout", drain_valid, 0);
        row_valid = 1'b0;
        drain_ready = 1'b1;
        chk("win_begin_8", drain_row, 8);
        chk("drain_q_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("run_after_drain", stall, 0);
        step;
        for (int i = 8; i < 16; i++) exp_q.push_back(4'(i));
        eof = 1'b1;
        @(negedge clk);
        chk("eof_stall", stall, 0);
        step;
        eof = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("eof_wait_stall", stall, 1);
            chk("eof_wait_idle", drain_valid, 0);
            step;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("final_fade_idle", drain_valid, 0);
            step;
        end
        chk("final_drain_start", drain_valid, 1);
        k = 0;
        while (drain_valid && k < 40) begin
            @(negedge clk);
            chk("final_no_early_done", done, 0);
            step;
            k++;
        end
        chk("final_timeout", drain_valid, 0);
        chk("done_pulse", done, 1);
        chk("final_q_empty", exp_q.size(), 0);
        step;
        chk("done_single", done, 0);
        chk("done_count", done_cnt, 1);
        chk("err_sticky", window_err, ERR_EXP);
        eof = 1'b1;
        step;
        eof = 1'b0;
        step;
        step;
        chk("mid_eof_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("arst_drain_valid", drain_valid, 0);
        chk("arst_stall", stall, 0);
        chk("arst_reject", row_reject, 0);
        chk("arst_done", done, 0);
        chk("arst_err", window_err, 0);
        chk("arst_drain_row", drain_row, 0);
        step;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step;
        chk("no_done_after_rst", done_cnt, 1);
        chk("idle_after_rst", stall, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
